seg_scan_controller: RTL

Time-multiplexed scan controller for the board's 8-digit seven-segment display. It holds a double-buffered 32-bit display word plus per-digit decimal-point and blank masks, and steps a 3-bit digit index at a programmable refresh rate. The index feeds the anode decoder directly; the nibble, dp and blank outputs feed the segment encoder. New content is committed only at frame boundaries, so a frame never shows a mix of old and new content.

---
 rtl/seg_scan_controller_if.sv | 25 ++
 rtl/seg_scan_controller.sv | 90 +++++++++
 2 files changed

// File: rtl/seg_scan_controller_if.sv
// Load channel for the seven-segment scan controller: one display frame per
// valid/ready transfer (hex digits, decimal-point mask, blank mask).
interface seg_scan_controller_if;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic [7:0]  load_dp;
   logic [7:0]  load_blank;

   modport master (
      output load_valid,
      output load_data,
      output load_dp,
      output load_blank,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_dp,
      input  load_blank,
      output load_ready
   );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display with a
// double-buffered frame that is only swapped in at frame boundaries.
module seg_scan_controller #(
   parameter int TICK_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   seg_scan_controller_if.slave  load,
   output logic [2:0]            digit_sel,
   output logic [3:0]            digit_val,
   output logic                  digit_dp,
   output logic                  digit_blank,
   output logic                  frame_done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pcnt;
   logic          tick;
   logic          wrap;
   logic          accept;
   logic          commit;
   logic          pending;

   logic [31:0]   act_data;
   logic [7:0]    act_dp;
   logic [7:0]    act_blank;
   logic [31:0]   shd_data;
   logic [7:0]    shd_dp;
   logic [7:0]    shd_blank;
   logic [4:0]    nib_lsb;

   assign tick            = en && (pcnt == PLAST);
   assign wrap            = tick && (digit_sel == 3'd7);
   assign load.load_ready = !pending;
   assign accept          = load.load_valid && !pending;
   // With scanning frozen there is no frame in progress, so a pending frame may go live at once.
   assign commit          = pending && (wrap || !en);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt       <= '0;
         digit_sel  <= 3'd0;
         frame_done <= 1'b0;
      end else begin
         if (en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
         end
         if (tick) begin
            digit_sel <= digit_sel + 3'd1;
         end
         frame_done <= wrap;
      end
   end

   // Accept and commit are mutually exclusive because accept needs pending low
   // and commit needs it high, so a frame accepted on a wrap waits for the next one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_data  <= 32'h0;
         act_dp    <= 8'h00;
         act_blank <= 8'hFF;
         shd_data  <= 32'h0;
         shd_dp    <= 8'h00;
         shd_blank <= 8'h00;
         pending   <= 1'b0;
      end else if (accept) begin
         shd_data  <= load.load_data;
         shd_dp    <= load.load_dp;
         shd_blank <= load.load_blank;
         pending   <= 1'b1;
      end else if (commit) begin
         act_data  <= shd_data;
         act_dp    <= shd_dp;
         act_blank <= shd_blank;
         pending   <= 1'b0;
      end
   end

   // Digit 0 is the leftmost, most-significant nibble.
   always_comb begin
      nib_lsb     = 5'd28 - {digit_sel, 2'b00};
      digit_val   = act_data[nib_lsb +: 4];
      digit_dp    = act_dp[digit_sel];
      digit_blank = act_blank[digit_sel];
   end

endmodule
